// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and parity engine FSM states.
package uart_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } par_state_e;

endpackage

// File: rtl/uart_parity_engine.sv
// Bit-serial UART parity engine: folds one data bit per clock behind a
// valid/ready load, supports even/odd/mark/space and runtime word length.
// Optional RX parity compare is built when PAR_CHECK_EN is defined.
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WLEN_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  BUSY,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic [WLEN_W-1:0]     WORD_LEN,
`ifdef PAR_CHECK_EN
  input  logic                  Rx_Par_Bit,
  output logic                  Par_Err,
`endif
  output logic                  Ready,
  output logic                  Par_Bit,
  output logic                  Par_Valid
);

  localparam logic [WLEN_W-1:0] MAX_LEN = WLEN_W'(DATA_WIDTH);

  par_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [WLEN_W-1:0]       len_q, len_d;
  logic [WLEN_W-1:0]       cnt_q, cnt_d;
  logic                    acc_q, acc_d;
  logic                    odd_q, odd_d;
  logic                    par_bit_q, par_bit_d;
  logic                    par_valid_q, par_valid_d;
`ifdef PAR_CHECK_EN
  logic                    rx_q, rx_d;
  logic                    par_err_q, par_err_d;
`endif

  logic                    load_c;
  logic [DATA_WIDTH-1:0]   data_shift_c;
  logic                    bit_c;
  logic                    result_c;

  assign Ready        = (state_q == ST_IDLE);
  assign load_c       = Data_Valid && Ready && !BUSY;
  assign data_shift_c = data_q >> cnt_q;
  assign bit_c        = data_shift_c[0];
  assign result_c     = acc_q ^ bit_c ^ odd_q;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      odd_q       <= 1'b0;
      par_bit_q   <= 1'b0;
      par_valid_q <= 1'b0;
`ifdef PAR_CHECK_EN
      rx_q        <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      odd_q       <= odd_d;
      par_bit_q   <= par_bit_d;
      par_valid_q <= par_valid_d;
`ifdef PAR_CHECK_EN
      rx_q        <= rx_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Next-state: load/clamp in IDLE, fold one bit per clock in CALC.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    odd_d       = odd_q;
    par_bit_d   = par_bit_q;
    par_valid_d = par_valid_q;
`ifdef PAR_CHECK_EN
    rx_d        = rx_q;
    par_err_d   = par_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (load_c) begin
          data_d      = P_DATA;
          len_d       = ((WORD_LEN == '0) || (WORD_LEN > MAX_LEN)) ? MAX_LEN : WORD_LEN;
          cnt_d       = '0;
          acc_d       = 1'b0;
          odd_d       = (PAR_MODE == PAR_ODD);
          par_valid_d = 1'b0;
`ifdef PAR_CHECK_EN
          rx_d        = Rx_Par_Bit;
          par_err_d   = 1'b0;
`endif
          if (PAR_EN && ((PAR_MODE == PAR_EVEN) || (PAR_MODE == PAR_ODD))) begin
            state_d = ST_CALC;
          end else begin
            // Fixed-value modes and disabled parity resolve on the load edge.
            par_bit_d   = PAR_EN && (PAR_MODE == PAR_MARK);
            par_valid_d = 1'b1;
`ifdef PAR_CHECK_EN
            par_err_d   = (Rx_Par_Bit != (PAR_EN && (PAR_MODE == PAR_MARK)));
`endif
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_q ^ bit_c;
        cnt_d = cnt_q + WLEN_W'(1);
        if (cnt_q == (len_q - WLEN_W'(1))) begin
          par_bit_d   = result_c;
          par_valid_d = 1'b1;
          state_d     = ST_IDLE;
`ifdef PAR_CHECK_EN
          par_err_d   = (rx_q != result_c);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Par_Bit   = par_bit_q;
  assign Par_Valid = par_valid_q;
`ifdef PAR_CHECK_EN
  assign Par_Err   = par_err_q;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: expected parity/latency pushed at
// load time, popped and compared when Par_Valid rises. Define PAR_CHECK_EN to
// also check Par_Err.
module tb_uart_parity_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic       bit_v;
    logic       err;
    logic [7:0] lat;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          BUSY;
  logic          PAR_EN;
  logic [1:0]    PAR_MODE;
  logic [LW-1:0] WORD_LEN;
  logic          Ready;
  logic          Par_Bit;
  logic          Par_Valid;
`ifdef PAR_CHECK_EN
  logic          Rx_Par_Bit;
  logic          Par_Err;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic last_bit;

  always #5 CLK = ~CLK;

  uart_parity_engine #(.DATA_WIDTH(DW), .WLEN_W(LW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .BUSY       (BUSY),
    .PAR_EN     (PAR_EN),
    .PAR_MODE   (PAR_MODE),
    .WORD_LEN   (WORD_LEN),
`ifdef PAR_CHECK_EN
    .Rx_Par_Bit (Rx_Par_Bit),
    .Par_Err    (Par_Err),
`endif
    .Ready      (Ready),
    .Par_Bit    (Par_Bit),
    .Par_Valid  (Par_Valid)
  );

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference parity model.
  function automatic logic model_par(input logic [7:0] d, input logic [1:0] m,
                                     input logic en, input logic [3:0] l);
    int   len;
    logic x;
    len = (l == 0 || l > 4'(DW)) ? DW : int'(l);
    if (!en) return 1'b0;
    if (m == 2'b10) return 1'b1;
    if (m == 2'b11) return 1'b0;
    x = 1'b0;
    for (int i = 0; i < len; i++) x = x ^ d[i];
    return (m == 2'b01) ? ~x : x;
  endfunction

  function automatic int model_lat(input logic [1:0] m, input logic en, input logic [3:0] l);
    if (!en || m[1]) return 0;
    return (l == 0 || l > 4'(DW)) ? DW : int'(l);
  endfunction

  // Drive one load at a negedge, then wait for and score the result.
  // glitch >= 0 pulses Data_Valid with 8'hFF that many cycles into the wait.
  task automatic do_load(input string tag, input logic [7:0] d, input logic [1:0] m,
                         input logic en, input logic [3:0] l, input logic rx,
                         input int glitch);
    exp_t e;
    exp_t got;
    int   n;
    e.bit_v = model_par(d, m, en, l);
    e.err   = (rx != e.bit_v);
    e.lat   = 8'(model_lat(m, en, l));
    sb_q.push_back(e);
    P_DATA = d; PAR_MODE = m; PAR_EN = en; WORD_LEN = l; Data_Valid = 1'b1;
`ifdef PAR_CHECK_EN
    Rx_Par_Bit = rx;
`endif
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA = 8'($urandom);
    PAR_MODE = 2'($urandom);
    chk({tag, "_rdy"}, 32'(Ready), 32'(e.lat == 0));
    n = 0;
    while (!Par_Valid && n < 30) begin
      if (n == glitch) begin
        Data_Valid = 1'b1; P_DATA = 8'hFF;
      end
      @(negedge CLK);
      Data_Valid = 1'b0;
      n++;
    end
    if (!Par_Valid) begin
      chk({tag, "_timeout"}, 32'(Par_Valid), 32'd1);
      void'(sb_q.pop_front());
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_bit"}, 32'(Par_Bit), 32'(got.bit_v));
      chk({tag, "_lat"}, 32'(n), 32'(got.lat));
      chk({tag, "_rdy_done"}, 32'(Ready), 32'd1);
`ifdef PAR_CHECK_EN
      chk({tag, "_err"}, 32'(Par_Err), 32'(got.err));
`endif
      last_bit = got.bit_v;
    end
  endtask

  initial begin
    RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; BUSY = 1'b0;
    PAR_EN = 1'b0; PAR_MODE = 2'b00; WORD_LEN = '0; last_bit = 1'b0;
`ifdef PAR_CHECK_EN
    Rx_Par_Bit = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_valid", 32'(Par_Valid), 32'd0);
    chk("rst_bit", 32'(Par_Bit), 32'd0);
`ifdef PAR_CHECK_EN
    chk("rst_err", 32'(Par_Err), 32'd0);
`endif
    RST = 1'b1;
    @(negedge CLK);

    // Directed cases.
    do_load("a5_even", 8'hA5, 2'b00, 1'b1, 4'd8, 1'b1, -1);
    do_load("a5_odd",  8'hA5, 2'b01, 1'b1, 4'd8, 1'b0, -1);
    do_load("ff_len5", 8'hFF, 2'b00, 1'b1, 4'd5, 1'b1, -1);
    do_load("len0",    8'h01, 2'b00, 1'b1, 4'd0, 1'b1, -1);
    do_load("len9",    8'h01, 2'b00, 1'b1, 4'd9, 1'b0, -1);
    do_load("mark",    8'h00, 2'b10, 1'b1, 4'd8, 1'b1, -1);
    do_load("space",   8'h00, 2'b11, 1'b1, 4'd8, 1'b1, -1);
    do_load("par_dis", 8'hA5, 2'b00, 1'b0, 4'd8, 1'b0, -1);
    do_load("glitch",  8'h07, 2'b00, 1'b1, 4'd8, 1'b0, 2);

    // Loads while BUSY are dropped; previous result stays valid.
    BUSY = 1'b1; Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_MODE = 2'b10; PAR_EN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("busy_valid", 32'(Par_Valid), 32'd1);
    chk("busy_bit", 32'(Par_Bit), 32'(last_bit));
    chk("busy_ready", 32'(Ready), 32'd1);
    BUSY = 1'b0; Data_Valid = 1'b0;
    do_load("after_busy", 8'h0B, 2'b01, 1'b1, 4'd4, 1'b1, -1);

    // Async reset mid-CALC.
    P_DATA = 8'hA5; PAR_MODE = 2'b01; PAR_EN = 1'b1; WORD_LEN = 4'd8; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_calc_busy", 32'(Ready), 32'd0);
    RST = 1'b0;
    #1;
    chk("mrst_ready", 32'(Ready), 32'd1);
    chk("mrst_valid", 32'(Par_Valid), 32'd0);
    chk("mrst_bit", 32'(Par_Bit), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    do_load("post_rst", 8'h03, 2'b00, 1'b1, 4'd8, 1'b1, -1);

    // Random back-to-back loads.
    for (int i = 0; i < 24; i++) begin
      do_load("rand", 8'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 9)), 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
